oam_dma: RTL and testbench



---
 rtl/gb_bus_pkg.sv | 28 ++
 rtl/oam_dma.sv | 119 +++++++++++
 tb/tb_oam_dma.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_bus_pkg.sv
// Shared bus definitions for the Game Boy style memory bus blocks.
//   dma_state_e  : OAM DMA sequencer state encoding
//   DMA_REG_ADDR : CPU address of the OAM DMA control register
//   OAM_BASE     : first OAM destination address
//   OAM_LENGTH   : bytes moved per OAM DMA transfer
//   echo_fold()  : maps a source page in the echo area back onto work RAM
package gb_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } dma_state_e;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam int          OAM_LENGTH   = 160;

    localparam logic [7:0]  ECHO_START   = 8'hE0;
    localparam logic [7:0]  ECHO_OFFSET  = 8'h20;

    // Pages E0..FF mirror C0..DF, so the DMA fetches from the real RAM page.
    function automatic logic [7:0] echo_fold(input logic [7:0] src);
        return (src >= ECHO_START) ? (src - ECHO_OFFSET) : src;
    endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: a CPU write to the control register names a source page;
// the block then copies LENGTH bytes from {page, index} to DEST_BASE + index,
// one READ cycle and one WRITE cycle per byte.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   cpu_addr/_data_w    : CPU-side address and write data
//   cpu_write_enable    : CPU write strobe
//   cpu_data_r          : control register read data (stored source page)
//   cpu_data_active     : high when this block is driving cpu_data_r
//   bus_addr/_data_w    : DMA-mastered memory bus address and write data
//   bus_write_enable    : DMA write strobe
//   bus_data_r          : memory read data, sampled at the end of READ
//   busy                : high while a transfer owns the memory bus
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no transfer; bus outputs parked at zero
// ST_START | one-cycle bus hand-over after a register write
// ST_READ  | drive source address, latch bus_data_r at the closing edge
// ST_WRITE | write latched byte to OAM, advance index or finish
module oam_dma
    import gb_bus_pkg::*;
#(
    parameter logic [15:0] REG_ADDR  = DMA_REG_ADDR,
    parameter logic [15:0] DEST_BASE = OAM_BASE,
    parameter int          LENGTH    = OAM_LENGTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_w,
    input  logic        cpu_write_enable,
    output logic [7:0]  cpu_data_r,
    output logic        cpu_data_active,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_data_w,
    output logic        bus_write_enable,
    input  logic [7:0]  bus_data_r,
    output logic        busy
);

    localparam logic [7:0] LAST_INDEX = 8'(LENGTH - 1);

    dma_state_e state_q, state_d;
    logic [7:0] index_q, index_d;
    logic [7:0] data_q,  data_d;
    logic [7:0] src_q,   src_d;

    logic       reg_hit;
    logic       reg_write;

    assign reg_hit         = (cpu_addr == REG_ADDR);
    assign reg_write       = reg_hit && cpu_write_enable;
    assign cpu_data_active = reg_hit && !cpu_write_enable;
    assign cpu_data_r      = src_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            index_q <= 8'h00;
            data_q  <= 8'h00;
            src_q   <= 8'hFF;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        index_d          = index_q;
        data_d           = data_q;
        src_d            = src_q;
        busy             = 1'b0;
        bus_write_enable = 1'b0;
        bus_addr         = 16'h0000;
        bus_data_w       = 8'h00;

        case (state_q)
            ST_IDLE: begin
            end
            ST_START: begin
                busy    = 1'b1;
                state_d = ST_READ;
            end
            ST_READ: begin
                busy     = 1'b1;
                bus_addr = {echo_fold(src_q), index_q};
                data_d   = bus_data_r;
                state_d  = ST_WRITE;
            end
            ST_WRITE: begin
                busy             = 1'b1;
                bus_addr         = DEST_BASE + {8'h00, index_q};
                bus_data_w       = data_q;
                bus_write_enable = 1'b1;
                if (index_q == LAST_INDEX) begin
                    state_d = ST_IDLE;
                end else begin
                    index_d = index_q + 8'd1;
                    state_d = ST_READ;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A register write always wins: the current cycle's bus outputs are
        // still driven, but the sequence restarts from index 0.
        if (reg_write) begin
            src_d   = cpu_data_w;
            index_d = 8'h00;
            state_d = ST_START;
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
module tb_oam_dma;

    localparam int LEN       = 160;
    localparam int BUSY_LEN  = 1 + 2 * LEN;

    logic        clk;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_w;
    logic        cpu_write_enable;
    logic [7:0]  cpu_data_r;
    logic        cpu_data_active;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data_w;
    logic        bus_write_enable;
    logic [7:0]  bus_data_r;
    logic        busy;

    oam_dma dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cpu_addr         (cpu_addr),
        .cpu_data_w       (cpu_data_w),
        .cpu_write_enable (cpu_write_enable),
        .cpu_data_r       (cpu_data_r),
        .cpu_data_active  (cpu_data_active),
        .bus_addr         (bus_addr),
        .bus_data_w       (bus_data_w),
        .bus_write_enable (bus_write_enable),
        .bus_data_r       (bus_data_r),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple memory responder
    logic [7:0] mem [0:65535];
    assign bus_data_r = mem[bus_addr];

    int vectors;
    int miscompares;

    // Bus monitor: samples once per cycle, mid-cycle
    logic [15:0] rd_q[$];
    logic [23:0] wr_q[$];
    int          busy_cnt;
    int          wr_total;

    always @(negedge clk) begin
        #1;
        if (bus_write_enable) wr_total++;
        if (busy) begin
            busy_cnt++;
            if (bus_write_enable) wr_q.push_back({bus_addr, bus_data_w});
            else                  rd_q.push_back(bus_addr);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    // Reference: source page after echo mirror, byte i lives at page*256+i
    function automatic int src_addr(input int src, input int i);
        int page;
        page = (src >= 224) ? src - 32 : src;
        return page * 256 + i;
    endfunction

    task automatic fill(input int src, input bit xor_pattern);
        for (int i = 0; i < LEN; i++) begin
            if (xor_pattern) mem[src_addr(src, i)] = 8'(i ^ 'h5A);
            else             mem[src_addr(src, i)] = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic trigger(input logic [7:0] src);
        @(negedge clk);
        cpu_addr         = 16'hFF46;
        cpu_data_w       = src;
        cpu_write_enable = 1'b1;
        @(negedge clk);
        cpu_write_enable = 1'b0;
        cpu_addr         = 16'h0000;
        rd_q.delete();
        wr_q.delete();
        busy_cnt = 0;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 2 * BUSY_LEN; c++) begin
            @(negedge clk);
            #2;
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        check({name, "_done"}, int'(done), 1);
    endtask

    task automatic verify(input int src, input string name);
        int n;
        check({name, "_busy_len"}, busy_cnt, BUSY_LEN);
        check({name, "_wr_count"}, wr_q.size(), LEN);
        check({name, "_rd_count"}, rd_q.size(), LEN + 1);
        n = (wr_q.size() < LEN) ? wr_q.size() : LEN;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_wr%0d", name, i), int'(wr_q[i]),
                  ((16'hFE00 + i) << 8) | int'(mem[src_addr(src, i)]));
        end
        n = (rd_q.size() < LEN + 1) ? rd_q.size() : LEN + 1;
        for (int i = 1; i < n; i++) begin
            check($sformatf("%s_rd%0d", name, i - 1), int'(rd_q[i]), src_addr(src, i - 1));
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        we;
        logic        exp_active;
        logic [7:0]  exp_data;
        logic        exp_busy;
    } reg_vec_t;

    reg_vec_t tbl[8];

    initial begin
        int snap;
        logic [7:0] s;

        vectors = 0;
        miscompares = 0;
        busy_cnt = 0;
        wr_total = 0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;

        tbl[0] = '{16'hFF46, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0};
        tbl[1] = '{16'hFF47, 8'h12, 1'b1, 1'b0, 8'hFF, 1'b0};
        tbl[2] = '{16'h0000, 8'h34, 1'b1, 1'b0, 8'hFF, 1'b0};
        tbl[3] = '{16'hFE00, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0};
        tbl[4] = '{16'hFF46, 8'h80, 1'b1, 1'b0, 8'hFF, 1'b1};
        tbl[5] = '{16'hFF46, 8'h00, 1'b0, 1'b1, 8'h80, 1'b1};
        tbl[6] = '{16'hFF45, 8'h00, 1'b0, 1'b0, 8'h80, 1'b1};
        tbl[7] = '{16'hFF46, 8'h00, 1'b0, 1'b1, 8'h80, 1'b1};

        rst_n            = 1'b0;
        cpu_addr         = 16'h0000;
        cpu_data_w       = 8'h00;
        cpu_write_enable = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_we", int'(bus_write_enable), 0);
        check("rst_addr", int'(bus_addr), 0);
        check("rst_wdata", int'(bus_data_w), 0);
        rst_n = 1'b1;

        // Register access table
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            cpu_addr         = tbl[v].addr;
            cpu_data_w       = tbl[v].wdata;
            cpu_write_enable = tbl[v].we;
            #1;
            check($sformatf("tbl%0d_active", v), int'(cpu_data_active), int'(tbl[v].exp_active));
            check($sformatf("tbl%0d_data", v), int'(cpu_data_r), int'(tbl[v].exp_data));
            @(negedge clk);
            #1;
            check($sformatf("tbl%0d_busy", v), int'(busy), int'(tbl[v].exp_busy));
            cpu_write_enable = 1'b0;
            cpu_addr         = 16'h0000;
        end
        wait_idle("tbl");

        // Directed transfers: xor pattern from C0, echo page F1, fold boundary
        fill('hC0, 1'b1);
        trigger(8'hC0);
        wait_idle("c0");
        verify('hC0, "c0");

        fill('hF1, 1'b0);
        trigger(8'hF1);
        wait_idle("f1");
        verify('hF1, "f1");

        fill('hE0, 1'b0);
        trigger(8'hE0);
        wait_idle("e0");
        verify('hE0, "e0");

        fill('hDF, 1'b0);
        trigger(8'hDF);
        wait_idle("df");
        verify('hDF, "df");

        // Randomized source pages and contents
        for (int t = 0; t < 4; t++) begin
            s = 8'($urandom_range(0, 255));
            fill(int'(s), 1'b0);
            trigger(s);
            wait_idle($sformatf("rnd%0d", t));
            verify(int'(s), $sformatf("rnd%0d", t));
        end

        // Rewrite mid-transfer restarts from index 0 of the new page
        fill('hC0, 1'b1);
        fill('hC1, 1'b0);
        trigger(8'hC0);
        repeat (49) @(negedge clk);
        trigger(8'hC1);
        wait_idle("restart");
        verify('hC1, "restart");

        // Reset mid-transfer aborts at once
        fill('hC0, 1'b1);
        trigger(8'hC0);
        repeat (99) @(negedge clk);
        #3;
        rst_n    = 1'b0;
        cpu_addr = 16'hFF46;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_we", int'(bus_write_enable), 0);
        check("abort_src", int'(cpu_data_r), 'hFF);
        check("abort_active", int'(cpu_data_active), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        snap  = wr_total;
        repeat (20) @(negedge clk);
        #2;
        check("abort_no_writes", wr_total - snap, 0);
        check("abort_idle", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
